// File: rtl/rob_tag_sequencer.sv
// In-order ROB tag allocator/retirer for the 1..2^TAG_W-1 tag space.
// Tag 0 is reserved as "no pending writer" and never handed out.
module rob_tag_sequencer #(
   parameter int TAG_W = 4
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             issue_valid,
   input  logic             issue_has_dest,
   input  logic [4:0]       issue_rd,
   input  logic             rs_space,
   output logic             issue_ready,
   output logic             issue_fire,
   output logic             issue_writes,
   output logic [4:0]       issue_dest,
   output logic [TAG_W-1:0] issue_ROB,
   input  logic             complete_valid,
   input  logic [TAG_W-1:0] complete_tag,
   input  logic             complete_mispredict,
   output logic             commit_valid,
   output logic [TAG_W-1:0] commit_ROB,
   output logic [4:0]       commit_dest,
   output logic             RegWrite,
   output logic             flush,
   output logic [TAG_W-1:0] count,
   output logic             empty,
   output logic             full
);

   localparam int DEPTH = 1 << TAG_W;
   localparam logic [TAG_W-1:0] MAX_TAG = TAG_W'(DEPTH - 1);
   localparam logic [TAG_W-1:0] TAG_ONE = TAG_W'(1);

   logic [TAG_W-1:0] head_q;
   logic [TAG_W-1:0] tail_q;
   logic [TAG_W-1:0] count_q;
   logic             flush_q;
   logic [DEPTH-1:0] valid_q;
   logic [DEPTH-1:0] done_q;
   logic [DEPTH-1:0] mispred_q;
   logic [DEPTH-1:0] has_dest_q;
   logic [4:0]       rd_q [DEPTH];

   logic             cpl_hit;
   logic             commit_flush;

   function automatic logic [TAG_W-1:0] next_tag(input logic [TAG_W-1:0] t);
      return (t == MAX_TAG) ? TAG_ONE : t + TAG_ONE;
   endfunction

   assign full  = (count_q == MAX_TAG);
   assign empty = (count_q == '0);
   assign count = count_q;
   assign flush = flush_q;

   // Held low during reset so nothing is accepted into a ROB being cleared
   assign issue_ready  = reset_n && !full && !flush_q;
   assign issue_fire   = issue_valid && rs_space && issue_ready;
   assign issue_ROB    = tail_q;
   assign issue_dest   = issue_rd;
   assign issue_writes = issue_fire && issue_has_dest && (issue_rd != 5'd0);

   assign commit_valid = valid_q[head_q] && done_q[head_q] && !flush_q;
   assign commit_ROB   = head_q;
   assign commit_dest  = rd_q[head_q];
   assign RegWrite     = commit_valid && has_dest_q[head_q] &&
                         (rd_q[head_q] != 5'd0);

   assign commit_flush = commit_valid && mispred_q[head_q];
   assign cpl_hit      = complete_valid && !flush_q &&
                         (complete_tag != '0) && valid_q[complete_tag];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         head_q     <= TAG_ONE;
         tail_q     <= TAG_ONE;
         count_q    <= '0;
         flush_q    <= 1'b0;
         valid_q    <= '0;
         done_q     <= '0;
         mispred_q  <= '0;
         has_dest_q <= '0;
         for (int i = 0; i < DEPTH; i++) rd_q[i] <= 5'd0;
      end else begin
         flush_q <= commit_flush;
         if (commit_flush) begin
            // Branch retires, everything younger (and any same-cycle issue) dies
            valid_q <= '0;
            head_q  <= TAG_ONE;
            tail_q  <= TAG_ONE;
            count_q <= '0;
         end else begin
            if (issue_fire) begin
               valid_q[tail_q]    <= 1'b1;
               done_q[tail_q]     <= 1'b0;
               mispred_q[tail_q]  <= 1'b0;
               has_dest_q[tail_q] <= issue_has_dest;
               rd_q[tail_q]       <= issue_rd;
               tail_q             <= next_tag(tail_q);
            end
            if (cpl_hit) begin
               done_q[complete_tag]    <= 1'b1;
               mispred_q[complete_tag] <= complete_mispredict;
            end
            if (commit_valid) begin
               valid_q[head_q] <= 1'b0;
               head_q          <= next_tag(head_q);
            end
            unique case ({issue_fire, commit_valid})
               2'b10:   count_q <= count_q + TAG_ONE;
               2'b01:   count_q <= count_q - TAG_ONE;
               default: count_q <= count_q;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_rob_tag_sequencer.sv
// Scoreboard bench for rob_tag_sequencer: issued entries are queued
// and matched against commits in order.
module tb_rob_tag_sequencer;

   logic       clk;
   logic       reset_n;
   logic       issue_valid;
   logic       issue_has_dest;
   logic [4:0] issue_rd;
   logic       rs_space;
   logic       issue_ready;
   logic       issue_fire;
   logic       issue_writes;
   logic [4:0] issue_dest;
   logic [3:0] issue_ROB;
   logic       complete_valid;
   logic [3:0] complete_tag;
   logic       complete_mispredict;
   logic       commit_valid;
   logic [3:0] commit_ROB;
   logic [4:0] commit_dest;
   logic       RegWrite;
   logic       flush;
   logic [3:0] count;
   logic       empty;
   logic       full;

   rob_tag_sequencer #(.TAG_W(4)) dut (
      .clk                 (clk),
      .reset_n             (reset_n),
      .issue_valid         (issue_valid),
      .issue_has_dest      (issue_has_dest),
      .issue_rd            (issue_rd),
      .rs_space            (rs_space),
      .issue_ready         (issue_ready),
      .issue_fire          (issue_fire),
      .issue_writes        (issue_writes),
      .issue_dest          (issue_dest),
      .issue_ROB           (issue_ROB),
      .complete_valid      (complete_valid),
      .complete_tag        (complete_tag),
      .complete_mispredict (complete_mispredict),
      .commit_valid        (commit_valid),
      .commit_ROB          (commit_ROB),
      .commit_dest         (commit_dest),
      .RegWrite            (RegWrite),
      .flush               (flush),
      .count               (count),
      .empty               (empty),
      .full                (full)
   );

   typedef struct {
      logic [3:0] tag;
      logic [4:0] rd;
      logic       rw;
   } sb_t;

   sb_t        sb[$];
   logic [3:0] model_tail;
   logic       mp_model [16];
   int         checks;
   int         errors;
   logic       saw_commit;
   logic [3:0] saw_tag;
   logic       saw_fire;
   logic       saw_ready;
   logic [3:0] last_rob;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog got timeout exp finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d exp %0d", tag, got, exp);
      end
   endtask

   function automatic logic [3:0] nxt(input logic [3:0] t);
      return (t == 4'd15) ? 4'd1 : t + 4'd1;
   endfunction

   task automatic drive(input logic iv, input logic hd, input logic [4:0] rd,
                        input logic cv, input logic [3:0] ct, input logic cm);
      issue_valid         = iv;
      issue_has_dest      = hd;
      issue_rd            = rd;
      rs_space            = 1'b1;
      complete_valid      = cv;
      complete_tag        = ct;
      complete_mispredict = cm;
   endtask

   // Called at negedge with inputs applied; observes, scores, then
   // advances one clock and returns at the next negedge.
   task automatic cycle();
      sb_t  e;
      logic do_flush;
      do_flush = 1'b0;
      #2;
      saw_commit = commit_valid;
      saw_tag    = commit_ROB;
      saw_fire   = issue_fire;
      saw_ready  = issue_ready;
      if (commit_valid) begin
         if (sb.size() == 0) begin
            chk("commit_unexpected", 32'(commit_ROB), 32'd0);
         end else begin
            e = sb.pop_front();
            chk("commit_rob", 32'(commit_ROB), 32'(e.tag));
            chk("commit_dest", 32'(commit_dest), 32'(e.rd));
            chk("regwrite", 32'(RegWrite), 32'(e.rw));
            do_flush = mp_model[e.tag];
         end
      end
      if (issue_fire) begin
         chk("issue_rob", 32'(issue_ROB), 32'(model_tail));
         chk("issue_dest", 32'(issue_dest), 32'(issue_rd));
         chk("issue_writes", 32'(issue_writes),
             32'(issue_has_dest && (issue_rd != 5'd0)));
         e.tag = model_tail;
         e.rd  = issue_rd;
         e.rw  = issue_has_dest && (issue_rd != 5'd0);
         sb.push_back(e);
         mp_model[model_tail] = 1'b0;
         last_rob   = issue_ROB;
         model_tail = nxt(model_tail);
      end
      if (complete_valid) mp_model[complete_tag] = complete_mispredict;
      if (do_flush) begin
         sb.delete();
         model_tail = 4'd1;
      end
      @(posedge clk);
      @(negedge clk);
      drive(1'b0, 1'b0, 5'd0, 1'b0, 4'd0, 1'b0);
   endtask

   task automatic model_reset();
      sb.delete();
      model_tail = 4'd1;
      for (int i = 0; i < 16; i++) mp_model[i] = 1'b0;
   endtask

   task automatic pulse_reset();
      reset_n = 1'b0;
      #1;
      reset_n = 1'b1;
      model_reset();
      @(negedge clk);
   endtask

   initial begin
      checks   = 0;
      errors   = 0;
      last_rob = 4'd0;
      reset_n  = 1'b0;
      drive(1'b0, 1'b0, 5'd0, 1'b0, 4'd0, 1'b0);
      model_reset();
      #3;
      chk("rst_ready", 32'(issue_ready), 32'd0);
      chk("rst_commit", 32'(commit_valid), 32'd0);
      chk("rst_regwrite", 32'(RegWrite), 32'd0);
      chk("rst_flush", 32'(flush), 32'd0);
      chk("rst_empty", 32'(empty), 32'd1);
      chk("rst_full", 32'(full), 32'd0);
      chk("rst_count", 32'(count), 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      #1;
      chk("post_rst_ready", 32'(issue_ready), 32'd1);
      @(negedge clk);

      // three issues, then out-of-order completion, in-order commit
      drive(1'b1, 1'b1, 5'd5, 1'b0, 4'd0, 1'b0); cycle();
      drive(1'b1, 1'b1, 5'd0, 1'b0, 4'd0, 1'b0); cycle();
      drive(1'b1, 1'b1, 5'd7, 1'b0, 4'd0, 1'b0); cycle();
      chk("count3", 32'(count), 32'd3);
      drive(1'b0, 1'b0, 5'd0, 1'b1, 4'd3, 1'b0); cycle();
      chk("no_commit_t3", 32'(saw_commit), 32'd0);
      drive(1'b0, 1'b0, 5'd0, 1'b1, 4'd1, 1'b0); cycle();
      chk("no_commit_same_cyc", 32'(saw_commit), 32'd0);
      cycle();
      chk("commit_t1", 32'(saw_commit), 32'd1);
      chk("commit_t1_tag", 32'(saw_tag), 32'd1);
      drive(1'b0, 1'b0, 5'd0, 1'b1, 4'd2, 1'b0); cycle();
      chk("t3_waits", 32'(saw_commit), 32'd0);
      cycle();
      chk("commit_t2_tag", 32'(saw_tag), 32'd2);
      cycle();
      chk("commit_t3", 32'(saw_commit), 32'd1);
      chk("commit_t3_tag", 32'(saw_tag), 32'd3);
      chk("empty_after", 32'(empty), 32'd1);

      // fill, wrap past tag 0, commit-vs-issue on full
      pulse_reset();
      for (int i = 1; i <= 15; i++) begin
         drive(1'b1, 1'b1, 5'(i), 1'b0, 4'd0, 1'b0);
         cycle();
      end
      chk("full", 32'(full), 32'd1);
      chk("full_ready", 32'(issue_ready), 32'd0);
      chk("full_count", 32'(count), 32'd15);
      chk("last_rob15", 32'(last_rob), 32'd15);
      drive(1'b1, 1'b1, 5'd9, 1'b1, 4'd1, 1'b0); cycle();
      chk("full_blocks", 32'(saw_fire), 32'd0);
      drive(1'b1, 1'b1, 5'd9, 1'b0, 4'd0, 1'b0); cycle();
      chk("full_commit", 32'(saw_commit), 32'd1);
      chk("full_no_fire", 32'(saw_fire), 32'd0);
      chk("count14", 32'(count), 32'd14);
      drive(1'b1, 1'b1, 5'd9, 1'b0, 4'd0, 1'b0); cycle();
      chk("wrap_fire", 32'(saw_fire), 32'd1);
      chk("wrap_rob1", 32'(last_rob), 32'd1);
      chk("count15", 32'(count), 32'd15);

      // mispredict flush
      pulse_reset();
      for (int i = 1; i <= 4; i++) begin
         drive(1'b1, 1'b1, 5'(i), 1'b0, 4'd0, 1'b0);
         cycle();
      end
      drive(1'b0, 1'b0, 5'd0, 1'b1, 4'd1, 1'b1); cycle();
      drive(1'b1, 1'b1, 5'd10, 1'b0, 4'd0, 1'b0); cycle();
      chk("mp_commit", 32'(saw_commit), 32'd1);
      chk("mp_commit_tag", 32'(saw_tag), 32'd1);
      chk("mp_ready", 32'(saw_ready), 32'd1);
      chk("flush_on", 32'(flush), 32'd1);
      chk("flush_ready", 32'(issue_ready), 32'd0);
      chk("flush_commit", 32'(commit_valid), 32'd0);
      chk("flush_count", 32'(count), 32'd0);
      drive(1'b1, 1'b1, 5'd11, 1'b1, 4'd3, 1'b0); cycle();
      chk("flush_no_fire", 32'(saw_fire), 32'd0);
      chk("flush_off", 32'(flush), 32'd0);
      chk("flush_count2", 32'(count), 32'd0);
      drive(1'b1, 1'b1, 5'd6, 1'b0, 4'd0, 1'b0); cycle();
      chk("post_flush_fire", 32'(saw_fire), 32'd1);
      chk("post_flush_rob", 32'(last_rob), 32'd1);
      cycle();
      chk("t3_cpl_ignored", 32'(saw_commit), 32'd0);

      // asynchronous reset with work in flight
      for (int i = 11; i <= 15; i++) begin
         drive(1'b1, 1'b1, 5'(i), 1'b0, 4'd0, 1'b0);
         cycle();
      end
      chk("count6", 32'(count), 32'd6);
      drive(1'b0, 1'b0, 5'd0, 1'b1, 4'd1, 1'b0);
      @(posedge clk);
      @(negedge clk);
      drive(1'b0, 1'b0, 5'd0, 1'b0, 4'd0, 1'b0);
      #1;
      chk("pre_rst_commit", 32'(commit_valid), 32'd1);
      reset_n = 1'b0;
      #1;
      chk("async_count", 32'(count), 32'd0);
      chk("async_empty", 32'(empty), 32'd1);
      chk("async_commit", 32'(commit_valid), 32'd0);
      chk("async_flush", 32'(flush), 32'd0);
      chk("async_ready", 32'(issue_ready), 32'd0);
      model_reset();
      @(negedge clk);
      reset_n = 1'b1;
      cycle();
      cycle();
      chk("final_empty", 32'(empty), 32'd1);
      chk("final_sb", 32'(sb.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
